nmea_sentence_sequencer: RTL and testbench
==========================================

NMEA_SENTENCE_SEQUENCER -- requirements
Module: nmea_sentence_sequencer

Interface
REQ-001 SHALL have parameter SYSCLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default SYSCLK_FREQ/100, the maximum number of idle cycles allowed between bytes inside a sentence.
REQ-003 SHALL have parameter NUM_FIELDS, default 14, the number of data fields required after the header.
REQ-004 SHALL have parameter MAX_LEN, default 82, the maximum number of bytes from '$' to LF inclusive.
REQ-005 sclk  in  1  sole clock; all logic on posedge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 dataByte  in  8  received UART byte.
REQ-008 dataReady  in  1  one-cycle strobe qualifying dataByte.
REQ-009 fieldByte  out  8  forwarded field character.
REQ-010 fieldValid  out  1  fieldByte/fieldIdx/charIdx valid, one-cycle pulse.
REQ-011 fieldIdx  out  4  current field number, 1..NUM_FIELDS.
REQ-012 charIdx  out  4  character position within field, 0-based.
REQ-013 fieldEnd  out  1  one-cycle pulse; field fieldIdx terminated.
REQ-014 sentenceDone  out  1  one-cycle pulse; sentence accepted.
REQ-015 sentenceErr  out  1  one-cycle pulse; sentence rejected.
REQ-016 errCode  out  3  reason for rejection, held until the next sentenceErr.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 States SHALL be IDLE, HEADER, BODY, CSUM_HI, CSUM_LO, EXP_CR, EXP_LF.
REQ-019 IDLE SHALL ignore all bytes except '$' (0x24), which moves to HEADER and clears the checksum accumulator, the length counter, fieldIdx and charIdx.
REQ-020 HEADER SHALL require the six bytes "GPGGA," in order; on any mismatch it SHALL go to IDLE with errCode 1.
REQ-021 On the header comma, fieldIdx SHALL be set to 1 and charIdx to 0, and the state SHALL move to BODY.
REQ-022 BODY, non-delimiter byte: fieldValid=1, fieldByte=byte, and charIdx increments after the byte, saturating at 15.
REQ-023 BODY, ',': fieldEnd=1, then fieldIdx increments and charIdx clears.
REQ-024 BODY, '*': fieldEnd=1; if fieldIdx==NUM_FIELDS, go to CSUM_HI; otherwise error code 5.
REQ-025 The checksum SHALL be the XOR of every byte strictly between '$' and '*', header included.
REQ-026 CSUM_HI/CSUM_LO SHALL accept only '0'-'9' and 'A'-'F'; any other byte gives error code 3.
REQ-027 After CSUM_LO, if the received value differs from the accumulated checksum, the result SHALL be error code 4; otherwise go to EXP_CR.
REQ-028 EXP_CR SHALL require 0x0D and EXP_LF SHALL require 0x0A; any other byte gives error code 5.
REQ-029 A valid LF SHALL produce sentenceDone=1 and return to IDLE.
REQ-030 The length counter SHALL count bytes from '$' inclusive; when a byte would make the count exceed MAX_LEN, the result SHALL be error code 2.
REQ-031 '$' received in any non-IDLE state SHALL produce error code 7, with sentenceErr pulsing that cycle, and SHALL restart at HEADER with cleared counters.
REQ-032 The timeout counter SHALL clear on every dataReady and increment otherwise while busy; on reaching TIMEOUT_CYCLES the result SHALL be error code 6 and the state SHALL go to IDLE.
REQ-033 If dataReady coincides with timeout expiry, the byte SHALL be processed and no timeout SHALL occur.
REQ-034 Every error SHALL pulse sentenceErr one cycle, load errCode, and go to IDLE (or HEADER per REQ-031).
REQ-035 All outputs SHALL be registered with latency of one cycle from dataReady.
REQ-036 At most one of fieldValid, fieldEnd, sentenceDone and sentenceErr SHALL be high in any cycle.
REQ-037 When dataReady is low, all pulses SHALL be 0, except sentenceErr on timeout.

Reset
REQ-038 While rst=1 at a posedge, the state SHALL be IDLE.
REQ-039 While rst=1, all pulses SHALL be 0, errCode=0, fieldIdx=0, charIdx=0, fieldByte=0, busy=0, and all counters and the accumulator SHALL be 0.
REQ-040 rst asserted mid-sentence SHALL abandon the sentence with no sentenceErr pulse.

Verification
REQ-041 NUM_FIELDS=1, bytes "$GPGGA,1*4B\r\n" -> one fieldValid (byte 0x31, fieldIdx 1, charIdx 0), one fieldEnd, sentenceDone one cycle after LF.
REQ-042 Same sentence with "*4C" -> sentenceErr after the 'C' byte, errCode 4, no sentenceDone.
REQ-043 "$GPGSV,..." -> sentenceErr on 'S' (0x53), errCode 1, and no fieldValid pulses.
REQ-044 TIMEOUT_CYCLES=100, "$GPG" then silence -> sentenceErr exactly 100 cycles after the last strobe, errCode 6, busy low the next cycle.
REQ-045 '$' injected mid-BODY followed by a valid sentence -> errCode 7 pulse, then sentenceDone for the second sentence.
REQ-046 83-byte sentence and rst asserted mid-field -> errCode 2 on byte 83; after reset all outputs zero and the next valid sentence is accepted.

Source files
------------

// File: rtl/nmea_sentence_sequencer.sv
// nmea_sentence_sequencer
// Frames $GPGGA sentences from a UART byte stream. Data field characters are
// forwarded with their field and character position. The XOR checksum is
// verified, then the CR/LF trailer. Malformed, overlong or stalled sentences
// are rejected with an error code.
module nmea_sentence_sequencer #(
  parameter int SYSCLK_FREQ    = 100_000_000,
  parameter int TIMEOUT_CYCLES = SYSCLK_FREQ / 100,
  parameter int NUM_FIELDS     = 14,
  parameter int MAX_LEN        = 82
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [7:0] dataByte,
  input  logic       dataReady,
  output logic [7:0] fieldByte,
  output logic       fieldValid,
  output logic [3:0] fieldIdx,
  output logic [3:0] charIdx,
  output logic       fieldEnd,
  output logic       sentenceDone,
  output logic       sentenceErr,
  output logic [2:0] errCode,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_BODY    = 3'd2;
  localparam logic [2:0] S_CSUM_HI = 3'd3;
  localparam logic [2:0] S_CSUM_LO = 3'd4;
  localparam logic [2:0] S_EXP_CR  = 3'd5;
  localparam logic [2:0] S_EXP_LF  = 3'd6;

  localparam logic [2:0] ERR_HEADER  = 3'd1;
  localparam logic [2:0] ERR_LENGTH  = 3'd2;
  localparam logic [2:0] ERR_HEX     = 3'd3;
  localparam logic [2:0] ERR_CSUM    = 3'd4;
  localparam logic [2:0] ERR_FRAME   = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] ERR_RESTART = 3'd7;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [2:0]    state, state_nxt;
  logic [2:0]    hdr_pos, hdr_pos_nxt;
  logic [7:0]    acc, acc_nxt;
  logic [LW-1:0] len, len_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [3:0]    fld_cnt, fld_cnt_nxt;
  logic [3:0]    chr_cnt, chr_cnt_nxt;
  logic [3:0]    csum_hi, csum_hi_nxt;

  logic [7:0] field_byte_nxt;
  logic [3:0] field_idx_nxt, char_idx_nxt;
  logic [2:0] err_code_nxt;
  logic       field_valid_nxt, field_end_nxt, done_nxt, err_nxt;

  logic       is_hex;
  logic [3:0] hex_val;
  logic [7:0] hdr_char;
  logic       fail;
  logic [2:0] fail_code;

  // Decode the incoming byte as an upper-case hex digit and pick the expected header character.
  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'd0;
    if (dataByte >= 8'h30 && dataByte <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = dataByte[3:0];
    end else if (dataByte >= 8'h41 && dataByte <= 8'h46) begin
      is_hex  = 1'b1;
      hex_val = dataByte[3:0] + 4'd9;
    end
    case (hdr_pos)
      3'd0:    hdr_char = 8'h47;  // G
      3'd1:    hdr_char = 8'h50;  // P
      3'd2:    hdr_char = 8'h47;  // G
      3'd3:    hdr_char = 8'h47;  // G
      3'd4:    hdr_char = 8'h41;  // A
      default: hdr_char = CH_COMMA;
    endcase
  end

  // Sentence state machine: compute next state, counters and output pulses.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt       = state;
    hdr_pos_nxt     = hdr_pos;
    acc_nxt         = acc;
    len_nxt         = len;
    tcnt_nxt        = tcnt;
    fld_cnt_nxt     = fld_cnt;
    chr_cnt_nxt     = chr_cnt;
    csum_hi_nxt     = csum_hi;
    field_byte_nxt  = fieldByte;
    field_idx_nxt   = fieldIdx;
    char_idx_nxt    = charIdx;
    err_code_nxt    = errCode;
    field_valid_nxt = 1'b0;
    field_end_nxt   = 1'b0;
    done_nxt        = 1'b0;
    err_nxt         = 1'b0;
    fail            = 1'b0;
    fail_code       = 3'd0;

    if (dataReady) begin
      // A byte always resets the inter-byte timer, even on the expiry cycle.
      tcnt_nxt = '0;
      if (dataByte == CH_DOLLAR) begin
        // '$' starts a sentence anywhere; outside IDLE it also aborts the old one.
        if (state != S_IDLE) begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_RESTART;
        end
        state_nxt     = S_HEADER;
        hdr_pos_nxt   = 3'd0;
        acc_nxt       = 8'd0;
        len_nxt       = LW'(1);
        fld_cnt_nxt   = 4'd0;
        chr_cnt_nxt   = 4'd0;
        field_idx_nxt = 4'd0;
        char_idx_nxt  = 4'd0;
      end else if (state != S_IDLE) begin
        if (len >= LW'(MAX_LEN)) begin
          fail      = 1'b1;
          fail_code = ERR_LENGTH;
        end else begin
          len_nxt = len + 1'b1;
          case (state)
            S_HEADER: begin
              if (dataByte != hdr_char) begin
                fail      = 1'b1;
                fail_code = ERR_HEADER;
              end else begin
                acc_nxt = acc ^ dataByte;
                if (hdr_pos == 3'd5) begin
                  state_nxt     = S_BODY;
                  fld_cnt_nxt   = 4'd1;
                  chr_cnt_nxt   = 4'd0;
                  field_idx_nxt = 4'd1;
                  char_idx_nxt  = 4'd0;
                end else begin
                  hdr_pos_nxt = hdr_pos + 3'd1;
                end
              end
            end
            S_BODY: begin
              if (dataByte == CH_COMMA) begin
                acc_nxt       = acc ^ dataByte;
                field_end_nxt = 1'b1;
                field_idx_nxt = fld_cnt;
                char_idx_nxt  = chr_cnt;
                fld_cnt_nxt   = (fld_cnt == 4'hF) ? 4'hF : fld_cnt + 4'd1;
                chr_cnt_nxt   = 4'd0;
              end else if (dataByte == CH_STAR) begin
                // A short or long field list is rejected instead of ending the field.
                if (fld_cnt == 4'(NUM_FIELDS)) begin
                  field_end_nxt = 1'b1;
                  field_idx_nxt = fld_cnt;
                  char_idx_nxt  = chr_cnt;
                  state_nxt     = S_CSUM_HI;
                end else begin
                  fail      = 1'b1;
                  fail_code = ERR_FRAME;
                end
              end else begin
                acc_nxt         = acc ^ dataByte;
                field_valid_nxt = 1'b1;
                field_byte_nxt  = dataByte;
                field_idx_nxt   = fld_cnt;
                char_idx_nxt    = chr_cnt;
                chr_cnt_nxt     = (chr_cnt == 4'hF) ? 4'hF : chr_cnt + 4'd1;
              end
            end
            S_CSUM_HI: begin
              if (!is_hex) begin
                fail      = 1'b1;
                fail_code = ERR_HEX;
              end else begin
                csum_hi_nxt = hex_val;
                state_nxt   = S_CSUM_LO;
              end
            end
            S_CSUM_LO: begin
              if (!is_hex) begin
                fail      = 1'b1;
                fail_code = ERR_HEX;
              end else if ({csum_hi, hex_val} != acc) begin
                fail      = 1'b1;
                fail_code = ERR_CSUM;
              end else begin
                state_nxt = S_EXP_CR;
              end
            end
            S_EXP_CR: begin
              if (dataByte == CH_CR) begin
                state_nxt = S_EXP_LF;
              end else begin
                fail      = 1'b1;
                fail_code = ERR_FRAME;
              end
            end
            S_EXP_LF: begin
              if (dataByte == CH_LF) begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
              end else begin
                fail      = 1'b1;
                fail_code = ERR_FRAME;
              end
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
    end else if (state != S_IDLE) begin
      if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        fail      = 1'b1;
        fail_code = ERR_TIMEOUT;
        tcnt_nxt  = '0;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end

    if (fail) begin
      err_nxt      = 1'b1;
      err_code_nxt = fail_code;
      state_nxt    = S_IDLE;
    end
  end

  // Register all state and outputs so every output lags dataReady by one cycle.
  always_ff @(posedge sclk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state        <= S_IDLE;
      hdr_pos      <= 3'd0;
      acc          <= 8'd0;
      len          <= '0;
      tcnt         <= '0;
      fld_cnt      <= 4'd0;
      chr_cnt      <= 4'd0;
      csum_hi      <= 4'd0;
      fieldByte    <= 8'd0;
      fieldIdx     <= 4'd0;
      charIdx      <= 4'd0;
      errCode      <= 3'd0;
      fieldValid   <= 1'b0;
      fieldEnd     <= 1'b0;
      sentenceDone <= 1'b0;
      sentenceErr  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      hdr_pos      <= hdr_pos_nxt;
      acc          <= acc_nxt;
      len          <= len_nxt;
      tcnt         <= tcnt_nxt;
      fld_cnt      <= fld_cnt_nxt;
      chr_cnt      <= chr_cnt_nxt;
      csum_hi      <= csum_hi_nxt;
      fieldByte    <= field_byte_nxt;
      fieldIdx     <= field_idx_nxt;
      charIdx      <= char_idx_nxt;
      errCode      <= err_code_nxt;
      fieldValid   <= field_valid_nxt;
      fieldEnd     <= field_end_nxt;
      sentenceDone <= done_nxt;
      sentenceErr  <= err_nxt;
      busy         <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_nmea_sentence_sequencer.sv
// Testbench for nmea_sentence_sequencer. Sentences are described at the text
// level; the expected per-byte events come from the sentence grammar, and the
// checksum is the XOR of the characters.
module tb_nmea_sentence_sequencer;

  localparam int NUM_F = 1;
  localparam int TOUT  = 100;
  localparam int MAXL  = 82;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_END   = 2;
  localparam int K_DONE  = 3;
  localparam int K_ERR   = 4;
  localparam int K_MULTI = 5;

  typedef struct {
    int         kind;
    logic [7:0] b;
    logic [3:0] fidx;
    logic [3:0] cidx;
    logic [2:0] code;
  } ev_t;

  typedef logic [7:0] bq_t [$];

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dataByte = 8'h00;
  logic       dataReady = 1'b0;
  logic [7:0] fieldByte;
  logic       fieldValid, fieldEnd, sentenceDone, sentenceErr, busy;
  logic [3:0] fieldIdx, charIdx;
  logic [2:0] errCode;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] tx_q[$];
  ev_t        ex_q[$];

  nmea_sentence_sequencer #(
    .TIMEOUT_CYCLES(TOUT),
    .NUM_FIELDS    (NUM_F),
    .MAX_LEN       (MAXL)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .dataByte    (dataByte),
    .dataReady   (dataReady),
    .fieldByte   (fieldByte),
    .fieldValid  (fieldValid),
    .fieldIdx    (fieldIdx),
    .charIdx     (charIdx),
    .fieldEnd    (fieldEnd),
    .sentenceDone(sentenceDone),
    .sentenceErr (sentenceErr),
    .errCode     (errCode),
    .busy        (busy)
  );

  always #5 sclk = ~sclk;

  function automatic ev_t mk(int k, logic [7:0] b, logic [3:0] f, logic [3:0] c, logic [2:0] code);
    ev_t e;
    e.kind = k; e.b = b; e.fidx = f; e.cidx = c; e.code = code;
    return e;
  endfunction

  function automatic void push(logic [7:0] b, ev_t e);
    tx_q.push_back(b);
    ex_q.push_back(e);
  endfunction

  function automatic void push_quiet_str(string s);
    for (int i = 0; i < s.len(); i++) push(s[i], mk(K_NONE, 0, 0, 0, 0));
  endfunction

  function automatic bq_t str2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [7:0] hexch(logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic int obs_kind();
    int n;
    n = int'(fieldValid) + int'(fieldEnd) + int'(sentenceDone) + int'(sentenceErr);
    if (n > 1) return K_MULTI;
    if (fieldValid) return K_VALID;
    if (fieldEnd) return K_END;
    if (sentenceDone) return K_DONE;
    if (sentenceErr) return K_ERR;
    return K_NONE;
  endfunction

  function automatic logic [23:0] out_vec();
    return {fieldByte, fieldValid, fieldIdx, charIdx, fieldEnd, sentenceDone,
            sentenceErr, errCode, busy};
  endfunction

  // Reference model: turn one "$GPGGA,<body>*hh\r\n" sentence into bytes and
  // expected events. mode 2 = bad hex digit, 3 = bad CR, 4 = bad LF; flip
  // corrupts the transmitted checksum.
  task automatic build(input bq_t body, input int mode, input logic [7:0] flip);
    string      hdr;
    logic [7:0] sum, sent, ch;
    int         f, c;
    hdr = "GPGGA,";
    sum = 8'h00;
    push(8'h24, mk(K_NONE, 0, 0, 0, 0));
    for (int i = 0; i < hdr.len(); i++) begin
      ch = hdr[i];
      sum ^= ch;
      push(ch, mk(K_NONE, 0, 0, 0, 0));
    end
    f = 1; c = 0;
    foreach (body[i]) begin
      ch = body[i];
      sum ^= ch;
      if (ch == 8'h2C) begin
        push(ch, mk(K_END, 0, 4'(f), 0, 0));
        f++; c = 0;
      end else begin
        push(ch, mk(K_VALID, ch, 4'(f), 4'((c > 15) ? 15 : c), 0));
        c++;
      end
    end
    if (f != NUM_F) begin
      push(8'h2A, mk(K_ERR, 0, 0, 0, 3'd5));
      return;
    end
    push(8'h2A, mk(K_END, 0, 4'(f), 0, 0));
    sent = sum ^ flip;
    if (mode == 2) begin
      push(8'h67, mk(K_ERR, 0, 0, 0, 3'd3));
      return;
    end
    push(hexch(sent[7:4]), mk(K_NONE, 0, 0, 0, 0));
    if (sent != sum) begin
      push(hexch(sent[3:0]), mk(K_ERR, 0, 0, 0, 3'd4));
      return;
    end
    push(hexch(sent[3:0]), mk(K_NONE, 0, 0, 0, 0));
    if (mode == 3) begin
      push(8'h0B, mk(K_ERR, 0, 0, 0, 3'd5));
      return;
    end
    push(8'h0D, mk(K_NONE, 0, 0, 0, 0));
    if (mode == 4) begin
      push(8'h0D, mk(K_ERR, 0, 0, 0, 3'd5));
      return;
    end
    push(8'h0A, mk(K_DONE, 0, 0, 0, 0));
  endtask

  // Strobe one byte at a negedge; on return the outputs of that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    dataByte  = b;
    dataReady = 1'b1;
    @(negedge sclk);
    dataReady = 1'b0;
  endtask

  // Drive queued bytes, compare each byte's registered response to the model.
  task automatic run_queue(input string name, input int max_gap);
    while (tx_q.size() > 0) begin
      ev_t        e;
      logic [7:0] b;
      int         k, gap;
      bit         ok;
      b = tx_q.pop_front();
      e = ex_q.pop_front();
      send_byte(b);
      k  = obs_kind();
      ok = (k == e.kind);
      if (ok && e.kind == K_VALID)
        ok = (fieldByte === e.b) && (fieldIdx === e.fidx) && (charIdx === e.cidx);
      if (ok && e.kind == K_END) ok = (fieldIdx === e.fidx);
      if (ok && e.kind == K_ERR) ok = (errCode === e.code);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s byte=0x%02h: got kind=%0d byte=%02h fidx=%0d cidx=%0d code=%0d, want kind=%0d byte=%02h fidx=%0d cidx=%0d code=%0d",
                 name, b, k, fieldByte, fieldIdx, charIdx, errCode,
                 e.kind, e.b, e.fidx, e.cidx, e.code);
      end
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        @(negedge sclk);
        n_cmp++;
        if (obs_kind() !== K_NONE) begin
          n_bad++;
          $display("FAIL %s idle_pulse: got kind=%0d, want 0", name, obs_kind());
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    n_cmp++;
    if (out_vec() !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %06h, want 000000", out_vec());
    end
    rst = 1'b0;
    @(negedge sclk);
    n_cmp++;
    if (out_vec() !== 24'h0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %06h, want 000000", out_vec());
    end
  endtask

  task automatic test_single_field();
    push_quiet_str("$GPGGA,");
    push(8'h31, mk(K_VALID, 8'h31, 4'd1, 4'd0, 0));
    push(8'h2A, mk(K_END, 0, 4'd1, 0, 0));
    push_quiet_str("4B\r");
    push(8'h0A, mk(K_DONE, 0, 0, 0, 0));
    run_queue("single_field", 0);
  endtask

  task automatic test_bad_checksum();
    build(str2q("1"), 0, 8'h07);  // transmits *4C
    push_quiet_str("\r\n");
    run_queue("bad_checksum", 1);
  endtask

  task automatic test_bad_header();
    push_quiet_str("$GPG");
    push(8'h53, mk(K_ERR, 0, 0, 0, 3'd1));
    push_quiet_str("V,3,1,2*00\r\n");
    run_queue("bad_header", 0);
  endtask

  task automatic test_timeout();
    int k;
    push_quiet_str("$GPG");
    run_queue("timeout_lead", 0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_busy: got %0b, want 1", busy);
    end
    k = 0;
    while (k < 150 && sentenceErr !== 1'b1) begin
      @(negedge sclk);
      k++;
    end
    n_cmp++;
    if (k !== TOUT) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, want %0d", k, TOUT);
    end
    n_cmp++;
    if (errCode !== 3'd6) begin
      n_bad++;
      $display("FAIL timeout_code: got %0d, want 6", errCode);
    end
    @(negedge sclk);
    n_cmp++;
    if (busy !== 1'b0 || sentenceErr !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_after: got busy=%0b err=%0b, want 0 0", busy, sentenceErr);
    end
  endtask

  task automatic test_timeout_race();
    bit early;
    push_quiet_str("$GP");
    run_queue("race_lead", 0);
    early = 1'b0;
    repeat (TOUT - 1) begin
      @(negedge sclk);
      if (sentenceErr) early = 1'b1;
    end
    n_cmp++;
    if (early) begin
      n_bad++;
      $display("FAIL race_early_timeout: got err=1, want 0");
    end
    // The next byte lands exactly on the expiry cycle and must win.
    push_quiet_str("GGA,");
    push(8'h31, mk(K_VALID, 8'h31, 4'd1, 4'd0, 0));
    push(8'h2A, mk(K_END, 0, 4'd1, 0, 0));
    push_quiet_str("4B\r");
    push(8'h0A, mk(K_DONE, 0, 0, 0, 0));
    run_queue("race_byte", 0);
  endtask

  task automatic test_restart();
    int idx;
    push_quiet_str("$GPGGA,");
    push(8'h31, mk(K_VALID, 8'h31, 4'd1, 4'd0, 0));
    push(8'h32, mk(K_VALID, 8'h32, 4'd1, 4'd1, 0));
    idx = ex_q.size();
    build(str2q("1"), 0, 8'h00);
    ex_q[idx] = mk(K_ERR, 0, 0, 0, 3'd7);
    run_queue("restart", 2);
  endtask

  task automatic test_max_len();
    logic [7:0] ch;
    push_quiet_str("$GPGGA,");
    for (int i = 0; i < 76; i++) begin
      ch = 8'(48 + i % 10);
      if (i < 75) push(ch, mk(K_VALID, ch, 4'd1, 4'((i > 15) ? 15 : i), 0));
      else        push(ch, mk(K_ERR, 0, 0, 0, 3'd2));
    end
    run_queue("max_len", 0);
  endtask

  task automatic test_reset_mid();
    push_quiet_str("$GPGGA,");
    push(8'h31, mk(K_VALID, 8'h31, 4'd1, 4'd0, 0));
    push(8'h32, mk(K_VALID, 8'h32, 4'd1, 4'd1, 0));
    run_queue("reset_mid_lead", 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge sclk);
      n_cmp++;
      if (out_vec() !== 24'h0) begin
        n_bad++;
        $display("FAIL reset_mid_outputs: got %06h, want 000000", out_vec());
      end
    end
    rst = 1'b0;
    @(negedge sclk);
    n_cmp++;
    if (out_vec() !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_mid_release: got %06h, want 000000", out_vec());
    end
    build(str2q("7"), 0, 8'h00);
    run_queue("reset_mid_next", 1);
  endtask

  task automatic test_back_to_back();
    build(str2q("123"), 0, 8'h00);
    build(str2q("4.5"), 0, 8'h00);
    build(str2q(""), 0, 8'h00);
    run_queue("back_to_back", 0);
  endtask

  task automatic test_random();
    string cs;
    cs = "0123456789.-NSEWM";
    for (int s = 0; s < 30; s++) begin
      bq_t        body;
      int         nf, mode, ng;
      logic [7:0] flip, g;
      ng = $urandom_range(0, 2);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h24) g = 8'h25;
        push(g, mk(K_NONE, 0, 0, 0, 0));
      end
      nf = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
      for (int f = 0; f < nf; f++) begin
        if (f > 0) body.push_back(8'h2C);
        for (int j = $urandom_range(0, 5); j > 0; j--)
          body.push_back(cs[$urandom_range(0, cs.len() - 1)]);
      end
      mode = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      flip = (mode == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      build(body, mode, flip);
      run_queue("random", 3);
    end
  endtask

  initial begin
    test_reset();
    test_single_field();
    test_bad_checksum();
    test_bad_header();
    test_timeout();
    test_timeout_race();
    test_restart();
    test_max_len();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
